// File: rtl/mcash_arb.sv
// Three-channel request arbiter and in-order return router in front of the mcash cache.
// Define MCASH_ARB_FIXED_PRIO_EN for fixed priority (ch0 > ch1 > ch2) instead of round-robin.
module mcash_arb #(
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,

    input  logic         mcash_ch0_req_valid_i,
    output logic         mcash_ch0_req_allowIn_o,
    input  logic [2:0]   mcash_ch0_req_op_i,
    input  logic [27:0]  mcash_ch0_req_addr_i,
    input  logic [127:0] mcash_ch0_req_data_i,
    output logic         mcash_ch0_rtn_valid_o,
    input  logic         mcash_ch0_rtn_ready_i,
    output logic [127:0] mcash_ch0_rtn_data_o,

    input  logic         mcash_ch1_req_valid_i,
    output logic         mcash_ch1_req_allowIn_o,
    input  logic [2:0]   mcash_ch1_req_op_i,
    input  logic [27:0]  mcash_ch1_req_addr_i,
    input  logic [127:0] mcash_ch1_req_data_i,
    output logic         mcash_ch1_rtn_valid_o,
    input  logic         mcash_ch1_rtn_ready_i,
    output logic [127:0] mcash_ch1_rtn_data_o,

    input  logic         mcash_ch2_req_valid_i,
    output logic         mcash_ch2_req_allowIn_o,
    input  logic [2:0]   mcash_ch2_req_op_i,
    input  logic [27:0]  mcash_ch2_req_addr_i,
    input  logic [127:0] mcash_ch2_req_data_i,
    output logic         mcash_ch2_rtn_valid_o,
    input  logic         mcash_ch2_rtn_ready_i,
    output logic [127:0] mcash_ch2_rtn_data_o,

    output logic         arb_req_valid_o,
    input  logic         arb_req_allowIn_i,
    output logic [2:0]   arb_req_op_o,
    output logic [27:0]  arb_req_addr_o,
    output logic [127:0] arb_req_data_o,
    output logic [1:0]   arb_req_ch_o,

    input  logic         arb_rtn_valid_i,
    output logic         arb_rtn_ready_o,
    input  logic [127:0] arb_rtn_data_i
);

    localparam int unsigned PW = $clog2(TAG_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(TAG_DEPTH);

    // Bit 3 pads the vectors so a 2-bit channel index never falls outside them.
    logic [3:0] valid_v;
    logic [3:0] rtn_ready_v;
    assign valid_v     = {1'b0, mcash_ch2_req_valid_i, mcash_ch1_req_valid_i,
                          mcash_ch0_req_valid_i};
    assign rtn_ready_v = {1'b0, mcash_ch2_rtn_ready_i, mcash_ch1_rtn_ready_i,
                          mcash_ch0_rtn_ready_i};

    logic           req_valid_q, req_valid_d;
    logic [2:0]     req_op_q, req_op_d;
    logic [27:0]    req_addr_q, req_addr_d;
    logic [127:0]   req_data_q, req_data_d;
    logic [1:0]     req_ch_q, req_ch_d;

    logic [1:0]     tag_mem_q [TAG_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  tag_cnt_q, tag_cnt_d;

    logic [1:0]     cand0, cand1, cand2;
    logic           win_valid;
    logic [1:0]     win_ch;
    logic [2:0]     win_op;
    logic [27:0]    win_addr;
    logic [127:0]   win_data;
    logic           free, room, accept, pop, tag_nempty;
    logic [1:0]     head;

`ifdef MCASH_ARB_FIXED_PRIO_EN
    assign cand0 = 2'd0;
    assign cand1 = 2'd1;
    assign cand2 = 2'd2;
`else
    logic [1:0] rr_q, rr_d;

    always_comb begin
        case (rr_q)
            2'd0: begin cand0 = 2'd1; cand1 = 2'd2; cand2 = 2'd0; end
            2'd1: begin cand0 = 2'd2; cand1 = 2'd0; cand2 = 2'd1; end
            default: begin cand0 = 2'd0; cand1 = 2'd1; cand2 = 2'd2; end
        endcase
    end

    assign rr_d = accept ? win_ch : rr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= 2'd2;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        win_valid = 1'b1;
        win_ch    = 2'd0;
        if (valid_v[cand0]) begin
            win_ch = cand0;
        end else if (valid_v[cand1]) begin
            win_ch = cand1;
        end else if (valid_v[cand2]) begin
            win_ch = cand2;
        end else begin
            win_valid = 1'b0;
        end
    end

    always_comb begin
        case (win_ch)
            2'd1: begin
                win_op = mcash_ch1_req_op_i; win_addr = mcash_ch1_req_addr_i;
                win_data = mcash_ch1_req_data_i;
            end
            2'd2: begin
                win_op = mcash_ch2_req_op_i; win_addr = mcash_ch2_req_addr_i;
                win_data = mcash_ch2_req_data_i;
            end
            default: begin
                win_op = mcash_ch0_req_op_i; win_addr = mcash_ch0_req_addr_i;
                win_data = mcash_ch0_req_data_i;
            end
        endcase
    end

    assign free   = ~req_valid_q | arb_req_allowIn_i;
    assign room   = (tag_cnt_q != FullCnt);
    // Reset gating keeps allowIn low while rst_i is held, even though state already looks idle.
    assign accept = win_valid & free & room & ~rst_i;

    assign mcash_ch0_req_allowIn_o = accept & (win_ch == 2'd0);
    assign mcash_ch1_req_allowIn_o = accept & (win_ch == 2'd1);
    assign mcash_ch2_req_allowIn_o = accept & (win_ch == 2'd2);

    always_comb begin
        req_valid_d = req_valid_q;
        req_op_d    = req_op_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_ch_d    = req_ch_q;
        if (accept) begin
            req_valid_d = 1'b1;
            req_op_d    = win_op;
            req_addr_d  = win_addr;
            req_data_d  = win_data;
            req_ch_d    = win_ch;
        end else if (req_valid_q && arb_req_allowIn_i) begin
            req_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_valid_q <= 1'b0;
            req_op_q    <= '0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_ch_q    <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            req_op_q    <= req_op_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_ch_q    <= req_ch_d;
        end
    end

    assign arb_req_valid_o = req_valid_q;
    assign arb_req_op_o    = req_op_q;
    assign arb_req_addr_o  = req_addr_q;
    assign arb_req_data_o  = req_data_q;
    assign arb_req_ch_o    = req_ch_q;

    assign tag_nempty      = (tag_cnt_q != '0);
    assign head            = tag_mem_q[rd_ptr_q];
    assign arb_rtn_ready_o = tag_nempty & rtn_ready_v[head];
    assign pop             = arb_rtn_valid_i & arb_rtn_ready_o;

    assign mcash_ch0_rtn_valid_o = arb_rtn_valid_i & tag_nempty & (head == 2'd0);
    assign mcash_ch1_rtn_valid_o = arb_rtn_valid_i & tag_nempty & (head == 2'd1);
    assign mcash_ch2_rtn_valid_o = arb_rtn_valid_i & tag_nempty & (head == 2'd2);
    assign mcash_ch0_rtn_data_o  = arb_rtn_data_i;
    assign mcash_ch1_rtn_data_o  = arb_rtn_data_i;
    assign mcash_ch2_rtn_data_o  = arb_rtn_data_i;

    always_comb begin
        tag_cnt_d = tag_cnt_q;
        case ({accept, pop})
            2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
            2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
            default: tag_cnt_d = tag_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tag_cnt_q <= '0;
            for (int i = 0; i < int'(TAG_DEPTH); i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            tag_cnt_q <= tag_cnt_d;
            if (accept) begin
                tag_mem_q[wr_ptr_q] <= win_ch;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mcash_arb.sv
// Scoreboard bench for mcash_arb: stimulus queues expected requests/returns, a monitor checks them.
module tb_mcash_arb;

    typedef struct {
        logic [1:0]   ch;
        logic [2:0]   op;
        logic [27:0]  addr;
        logic [127:0] data;
    } req_t;

    typedef struct {
        logic [1:0]   ch;
        logic [127:0] data;
    } rtn_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   vld;
    logic [2:0]   op    [3];
    logic [27:0]  addr  [3];
    logic [127:0] wdata [3];
    logic [2:0]   allow;
    logic [2:0]   rvld;
    logic [2:0]   rrdy;
    logic [127:0] rdata [3];
    logic         a_vld, a_allow;
    logic [2:0]   a_op;
    logic [27:0]  a_addr;
    logic [127:0] a_data;
    logic [1:0]   a_ch;
    logic         r_vld_i, r_rdy;
    logic [127:0] r_data;

    int vectors = 0;
    int miscompares = 0;
    req_t exp_req [$];
    rtn_t exp_rtn [$];
    req_t me;
    rtn_t mr;

    always #5 clk = ~clk;

    mcash_arb #(.TAG_DEPTH(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .mcash_ch0_req_valid_i(vld[0]), .mcash_ch0_req_allowIn_o(allow[0]),
        .mcash_ch0_req_op_i(op[0]), .mcash_ch0_req_addr_i(addr[0]),
        .mcash_ch0_req_data_i(wdata[0]), .mcash_ch0_rtn_valid_o(rvld[0]),
        .mcash_ch0_rtn_ready_i(rrdy[0]), .mcash_ch0_rtn_data_o(rdata[0]),
        .mcash_ch1_req_valid_i(vld[1]), .mcash_ch1_req_allowIn_o(allow[1]),
        .mcash_ch1_req_op_i(op[1]), .mcash_ch1_req_addr_i(addr[1]),
        .mcash_ch1_req_data_i(wdata[1]), .mcash_ch1_rtn_valid_o(rvld[1]),
        .mcash_ch1_rtn_ready_i(rrdy[1]), .mcash_ch1_rtn_data_o(rdata[1]),
        .mcash_ch2_req_valid_i(vld[2]), .mcash_ch2_req_allowIn_o(allow[2]),
        .mcash_ch2_req_op_i(op[2]), .mcash_ch2_req_addr_i(addr[2]),
        .mcash_ch2_req_data_i(wdata[2]), .mcash_ch2_rtn_valid_o(rvld[2]),
        .mcash_ch2_rtn_ready_i(rrdy[2]), .mcash_ch2_rtn_data_o(rdata[2]),
        .arb_req_valid_o(a_vld), .arb_req_allowIn_i(a_allow),
        .arb_req_op_o(a_op), .arb_req_addr_o(a_addr), .arb_req_data_o(a_data),
        .arb_req_ch_o(a_ch),
        .arb_rtn_valid_i(r_vld_i), .arb_rtn_ready_o(r_rdy), .arb_rtn_data_i(r_data)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input int ch);
        req_t e;
        e.ch   = 2'(ch);
        e.op   = op[ch];
        e.addr = addr[ch];
        e.data = wdata[ch];
        exp_req.push_back(e);
    endtask

    task automatic push_rtn(input int ch, input logic [127:0] d);
        rtn_t e;
        e.ch   = 2'(ch);
        e.data = d;
        exp_rtn.push_back(e);
    endtask

    task automatic do_reset();
        vld     = 3'b000;
        r_vld_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every request/return handshake must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_vld && a_allow) begin
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", 1, 0);
                end else begin
                    me = exp_req.pop_front();
                    chk("req_ch", a_ch, me.ch);
                    chk("req_op", a_op, me.op);
                    chk("req_addr", a_addr, me.addr);
                    chk("req_data", a_data, me.data);
                end
            end
            if (r_vld_i && r_rdy) begin
                if (exp_rtn.size() == 0) begin
                    chk("rtn_unexpected", 1, 0);
                end else begin
                    mr = exp_rtn.pop_front();
                    chk("rtn_route", rvld, 3'b001 << mr.ch);
                    chk("rtn_data", rdata[mr.ch], mr.data);
                end
            end
        end
    end

    initial begin
        int exp_ch;
        rst     = 1'b1;
        vld     = 3'b111;
        a_allow = 1'b1;
        r_vld_i = 1'b0;
        r_data  = '0;
        rrdy    = 3'b111;
        for (int n = 0; n < 3; n++) begin
            op[n]    = 3'(n + 1);
            addr[n]  = 28'h100 * 28'(n + 1);
            wdata[n] = {4{32'hC0DE_0000 + 32'(n)}};
        end

        // Reset values with every request valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_allowIn", allow, 3'b000);
        chk("rst_req_valid", a_vld, 0);
        chk("rst_req_ch", a_ch, 0);
        chk("rst_req_addr", a_addr, 0);
        chk("rst_rtn_ready", r_rdy, 0);
        tick();
        rst = 1'b0;

        // Round-robin with all channels valid
        for (int i = 0; i < 6; i++) begin
`ifdef MCASH_ARB_FIXED_PRIO_EN
            exp_ch = 0;
`else
            exp_ch = i % 3;
`endif
            push_req(exp_ch);
            @(negedge clk);
            chk("rr_allowIn", allow, 3'b001 << exp_ch);
            tick();
        end
        vld = 3'b000;

        // Reset mid-operation drops outstanding tags; a return afterwards is spurious
        tick();
        rst     = 1'b1;
        r_vld_i = 1'b1;
        r_data  = 128'hDEAD;
        tick();
        @(negedge clk);
        chk("rst_mid_req_valid", a_vld, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rtn_ready", r_rdy, 0);
        chk("post_rst_rtn_valid", rvld, 3'b000);
        tick();
        r_vld_i = 1'b0;

        // Backpressure: ch1 addr 2 held while the cache stalls
        a_allow = 1'b0;
        vld     = 3'b010;
        addr[1] = 28'h2;
        push_req(1);
        @(negedge clk);
        chk("bp_first_allowIn", allow, 3'b010);
        tick();
        vld     = 3'b011;
        addr[1] = 28'h3;
        addr[0] = 28'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_addr", a_addr, 28'h2);
            chk("bp_hold_ch", a_ch, 1);
            chk("bp_allowIn", allow, 3'b000);
            tick();
        end
        a_allow = 1'b1;
        push_req(0);
        @(negedge clk);
        chk("bp_release_allowIn", allow, 3'b001);
        tick();
        vld = 3'b010;
        push_req(1);
        @(negedge clk);
        chk("bp_next_allowIn", allow, 3'b010);
        tick();
        do_reset();

        // Tag FIFO full after eight accepts; one pop lets exactly one more in
        vld = 3'b001;
        for (int i = 0; i < 8; i++) begin
            addr[0] = 28'h10 + 28'(i);
            push_req(0);
            @(negedge clk);
            chk("fill_allowIn", allow, 3'b001);
            tick();
        end
        addr[0] = 28'h20;
        @(negedge clk);
        chk("full_allowIn", allow, 3'b000);
        tick();
        r_vld_i = 1'b1;
        rrdy    = 3'b001;
        r_data  = 128'hAA;
        push_rtn(0, 128'hAA);
        @(negedge clk);
        chk("full_pop_allowIn", allow, 3'b000);
        tick();
        r_vld_i = 1'b0;
        push_req(0);
        @(negedge clk);
        chk("after_pop_allowIn", allow, 3'b001);
        tick();
        @(negedge clk);
        chk("refull_allowIn", allow, 3'b000);
        tick();
        do_reset();

        // Return routing in issue order ch2, ch0, ch1 with a ch0 stall
        vld = 3'b100;
        push_req(2);
        tick();
        vld = 3'b001;
        push_req(0);
        tick();
        vld = 3'b010;
        push_req(1);
        tick();
        vld     = 3'b000;
        rrdy    = 3'b110;
        r_vld_i = 1'b1;
        r_data  = 128'hA;
        push_rtn(2, 128'hA);
        tick();
        r_data = 128'hB;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_rtn_ready", r_rdy, 0);
            chk("stall_rtn_valid", rvld, 3'b001);
            tick();
        end
        rrdy = 3'b111;
        push_rtn(0, 128'hB);
        tick();
        r_data = 128'hC;
        push_rtn(1, 128'hC);
        tick();

        // Spurious return with nothing outstanding
        r_data = 128'hE;
        @(negedge clk);
        chk("spurious_rtn_ready", r_rdy, 0);
        chk("spurious_rtn_valid", rvld, 3'b000);
        tick();
        r_vld_i = 1'b0;

        for (int i = 0; i < 20 && (exp_req.size() != 0 || exp_rtn.size() != 0); i++) begin
            tick();
        end
        chk("req_queue_drained", exp_req.size(), 0);
        chk("rtn_queue_drained", exp_rtn.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
